systolic_skew_feeder: RTL

Producer side of the systolic array's west/north data interface. It accepts one K-step of operands per cycle: a column slice of A for the rows and a row slice of B for the columns. It then drives them into the array as diagonal wavefronts: row i delayed i cycles, column j delayed j cycles. It sequences a K-length job, holds the SIMD mode stable for the whole job, inserts zeros for bubbles, and signals completion once the last product has reached the far-corner PE.

---
 rtl/systolic_skew_feeder_pkg.sv | 19 +
 rtl/skew_delay_line.sv | 32 +++
 rtl/systolic_skew_feeder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/systolic_skew_feeder_pkg.sv
// Shared definitions for the systolic feed/drain side: controller state
// encoding and the drain-latency derivation reused by the drain logic.
package systolic_skew_feeder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } feeder_state_e;

  // Cycles for the last operand pair to cross the array diagonal and be accumulated.
  function automatic int unsigned flush_len(input int unsigned h,
                                            input int unsigned w,
                                            input int unsigned pe_lat);
    return (h - 1) + (w - 1) + pe_lat;
  endfunction

endpackage

// File: rtl/skew_delay_line.sv
// DEPTH-stage shift register with asynchronous active-low clear;
// DEPTH=0 degenerates to a plain wire.
module skew_delay_line #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  if (DEPTH == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst_n;
    assign q_o = d_i;
  end else begin : g_shift
    logic [WIDTH-1:0] sr_q [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned s = 0; s < DEPTH; s++) sr_q[s] <= '0;
      end else begin
        sr_q[0] <= d_i;
        for (int unsigned s = 1; s < DEPTH; s++) sr_q[s] <= sr_q[s-1];
      end
    end

    assign q_o = sr_q[DEPTH-1];
  end

endmodule

// File: rtl/systolic_skew_feeder.sv
// West/north operand feeder for the systolic array: sequences a K-length job
// and skews A rows / B columns into diagonal wavefronts.
module systolic_skew_feeder
  import systolic_skew_feeder_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned ARR_HEIGHT = 4,
  parameter int unsigned ARR_WIDTH  = 4,
  parameter int unsigned K_BITS     = 8,
  parameter int unsigned PE_LAT     = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic [K_BITS-1:0]           k_len,
  input  logic [1:0]                  simd_in,
  input  logic                        op_valid,
  output logic                        op_ready,
  input  logic [ARR_HEIGHT*WIDTH-1:0] a_data,
  input  logic [ARR_WIDTH*WIDTH-1:0]  b_data,
  output logic [ARR_HEIGHT*WIDTH-1:0] out_a,
  output logic [ARR_WIDTH*WIDTH-1:0]  out_b,
  output logic [1:0]                  SIMD_control,
  output logic                        busy,
  output logic                        done
);

  localparam int unsigned FLUSH_LEN = flush_len(ARR_HEIGHT, ARR_WIDTH, PE_LAT);
  localparam int unsigned K_MAX     = (32'd1 << K_BITS) - 32'd1;
  localparam int unsigned CNT_MAX   = (K_MAX > FLUSH_LEN) ? K_MAX : FLUSH_LEN;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);

  feeder_state_e state_q, state_d;
  logic [K_BITS-1:0]           k_len_q, k_len_d;
  logic [1:0]                  simd_q, simd_d;
  logic [CNT_W-1:0]            k_cnt_q, k_cnt_d;
  logic [CNT_W-1:0]            flush_cnt_q, flush_cnt_d;
  logic                        done_q, done_d;
  logic [ARR_HEIGHT*WIDTH-1:0] a_s0_q, a_s0_d;
  logic [ARR_WIDTH*WIDTH-1:0]  b_s0_q, b_s0_d;
  logic                        xfer;
  logic                        k_last;

  assign xfer   = op_valid && (state_q == FEED);
  assign k_last = (k_cnt_q == (CNT_W'(k_len_q) - CNT_W'(1)));

  always_comb begin
    state_d     = state_q;
    k_len_d     = k_len_q;
    simd_d      = simd_q;
    k_cnt_d     = k_cnt_q;
    flush_cnt_d = flush_cnt_q;
    done_d      = (state_q == DONE);
    // Bubbles and drain cycles feed zeros, which leave the MACs unchanged.
    a_s0_d      = xfer ? a_data : '0;
    b_s0_d      = xfer ? b_data : '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          k_len_d     = k_len;
          simd_d      = simd_in;
          k_cnt_d     = '0;
          flush_cnt_d = '0;
          state_d     = (k_len == '0) ? DONE : FEED;
        end
      end
      FEED: begin
        if (xfer) begin
          k_cnt_d = k_cnt_q + CNT_W'(1);
          if (k_last) begin
            flush_cnt_d = '0;
            state_d     = FLUSH;
          end
        end
      end
      FLUSH: begin
        if (flush_cnt_q == CNT_W'(FLUSH_LEN - 1)) state_d = DONE;
        else flush_cnt_d = flush_cnt_q + CNT_W'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      k_len_q     <= '0;
      simd_q      <= '0;
      k_cnt_q     <= '0;
      flush_cnt_q <= '0;
      done_q      <= 1'b0;
      a_s0_q      <= '0;
      b_s0_q      <= '0;
    end else begin
      state_q     <= state_d;
      k_len_q     <= k_len_d;
      simd_q      <= simd_d;
      k_cnt_q     <= k_cnt_d;
      flush_cnt_q <= flush_cnt_d;
      done_q      <= done_d;
      a_s0_q      <= a_s0_d;
      b_s0_q      <= b_s0_d;
    end
  end

  assign op_ready     = (state_q == FEED);
  assign busy         = (state_q == FEED) || (state_q == FLUSH);
  assign done         = done_q;
  assign SIMD_control = simd_q;

  // Stage 0 is the shared input register; lane n adds n further stages.
  for (genvar i = 0; i < ARR_HEIGHT; i++) begin : g_a_lane
    skew_delay_line #(.WIDTH(WIDTH), .DEPTH(i)) u_dly (
      .clk   (clk),
      .rst_n (reset),
      .d_i   (a_s0_q[i*WIDTH +: WIDTH]),
      .q_o   (out_a[i*WIDTH +: WIDTH])
    );
  end

  for (genvar j = 0; j < ARR_WIDTH; j++) begin : g_b_lane
    skew_delay_line #(.WIDTH(WIDTH), .DEPTH(j)) u_dly (
      .clk   (clk),
      .rst_n (reset),
      .d_i   (b_s0_q[j*WIDTH +: WIDTH]),
      .q_o   (out_b[j*WIDTH +: WIDTH])
    );
  end

endmodule
